modulo_abastecimento_rolhas_principal: RTL and testbench
========================================================

# modulo_abastecimento_rolhas_principal

Primary cork reservoir controller for the filling/sealing line. Sits between the secondary cork buffer and the filling/sealing state machine. Holds the primary cork count and refills it from the secondary buffer, one cork per two-cycle handshake, whenever the count falls below a threshold. Drives the cork-absence flag `ro`, the low-level flag and the count to the display encoders.

## Interface
Parameters:
- `CAP_PRI`, 15: primary reservoir capacity in corks. Refill stops when this is reached.
- `MIN_PRI`, 5: refill trigger. A refill starts when the count is strictly below this value.

Ports:
- `clk`, in, 1: system clock (divided clock domain).
- `clr`, in, 1: reset. Asynchronous, active-high.
- `enable`, in, 1: line running (start/stop). When low, no new transfer starts.
- `consome`, in, 1: one-cycle pulse; one cork used by sealing (`ve` AND `cq`).
- `sec_count`, in, 7: current secondary buffer count, 0..99. Registered externally and updates 1 cycle after `sec_dec`.
- `sec_dec`, out, 1: one-cycle pulse requesting the secondary buffer to decrement by 1.
- `pri_count`, out, 7: primary reservoir count, 0..`CAP_PRI`.
- `ro`, out, 1: high when `pri_count == 0`.
- `pri_baixo`, out, 1: high when `pri_count < MIN_PRI`.
- `transferindo`, out, 1: high in states TRANSFER and SETTLE.
- `falta_sec`, out, 1: high in state STARVED.

## Operation
- FSM states: IDLE, TRANSFER, SETTLE, STARVED. Reset state is IDLE.
- IDLE:
  - goes to TRANSFER if `enable` AND `pri_count < MIN_PRI` AND `sec_count != 0`;
  - goes to STARVED if `enable` AND `pri_count < MIN_PRI` AND `sec_count == 0`;
  - otherwise stays in IDLE.
- TRANSFER (1 cycle):
  - `sec_dec = 1`;
  - `pri_count` increments by 1, less 1 if `consome` is high in the same cycle;
  - always goes to SETTLE.
- SETTLE (1 cycle, no `sec_dec`; waits for `sec_count` to update):
  - goes to IDLE if `!enable` OR `pri_count == CAP_PRI`;
  - goes to STARVED if `sec_count == 0`;
  - otherwise goes back to TRANSFER.
  - A refill therefore continues to `CAP_PRI`, not just to `MIN_PRI`.
- STARVED:
  - `falta_sec = 1`;
  - goes to TRANSFER when `sec_count != 0` AND `enable`;
  - goes to IDLE if `!enable` OR `pri_count >= MIN_PRI`.
- Count update rules, applied in every state:
  - `consome` with `pri_count > 0` decrements the count;
  - `consome` with `pri_count == 0` is ignored and the count stays 0 (no wrap);
  - in TRANSFER, `consome` with `pri_count == 0` nets +1 (the consume is ignored).
- Width rule: `pri_count` is 7 bits and never exceeds `CAP_PRI`. A TRANSFER never starts from `pri_count == CAP_PRI`.
- `sec_dec` is issued only while `sec_count != 0` was sampled on entry to TRANSFER. The secondary count never underflows because of this block.

## Timing
- Reset values: `pri_count = 0`, `sec_dec = 0`, `transferindo = 0`, `falta_sec = 0`, `ro = 1`, `pri_baixo = 1`. The FSM is in IDLE.
- All outputs are registered or decoded only from registers. No input-to-output combinational path.
- Refill throughput: 1 cork per 2 cycles. Refill from 4 to 15 takes 22 cycles from the first TRANSFER when there is no consumption.
- Trigger latency: a count below `MIN_PRI` at edge N gives TRANSFER and `sec_dec` during cycle N+1.
- `clr` asserted mid-transfer: immediate return to reset values. A pending `sec_dec` is dropped and `pri_count` returns to 0.
- `enable` falling in TRANSFER: the current cork completes, then SETTLE, then IDLE.

## Structure
- Shared package `pkg_rolhas` holds:
  - the state typedef (IDLE=2'b00, TRANSFER=2'b01, SETTLE=2'b10, STARVED=2'b11);
  - `CAP_PRI`, `MIN_PRI`;
  - `MAX_SEC = 99`.
- Sub-module `modulo_mef_transferencia_rolhas`: the FSM (state register, next-state logic, `sec_dec`/`falta_sec`).
- The top level holds the saturating up/down `pri_count` register and the flag decode.

## Test plan
- Reset, `enable = 1`, `sec_count = 20`, no consumption → 15 `sec_dec` pulses 2 cycles apart; `pri_count` reaches 15; IDLE; `ro` falls after the first transfer.
- `pri_count = 15`, `sec_count = 3`, 11 `consome` pulses → transfer starts at count 4; 3 pulses; then STARVED with `falta_sec = 1` and `pri_count = 7`.
- STARVED, then `sec_count` set to 10 → TRANSFER next cycle; refill resumes to 15.
- `consome` coincident with every TRANSFER cycle → `pri_count` unchanged by those cycles; `sec_dec` count equals the number of TRANSFER cycles.
- `pri_count = 0`, `consome` pulses with `enable = 0` → count stays 0; `ro = 1`; no `sec_dec`.
- `clr` asserted in a TRANSFER cycle → all outputs at reset values at the next sample; no further `sec_dec`.

Source files
------------

// File: rtl/pkg_rolhas.sv
// Shared types and limits for the primary cork reservoir.
package pkg_rolhas;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    TRANSFER = 2'b01,
    SETTLE   = 2'b10,
    STARVED  = 2'b11
  } estado_t;

  localparam int CAP_PRI = 15;
  localparam int MIN_PRI = 5;
  localparam int MAX_SEC = 99;

endpackage

// File: rtl/modulo_mef_transferencia_rolhas.sv
// Transfer FSM: pulls one cork from the secondary buffer per two cycles
// while the primary reservoir is being refilled.
module modulo_mef_transferencia_rolhas
  import pkg_rolhas::*;
#(
  parameter int CAP_PRI = pkg_rolhas::CAP_PRI,
  parameter int MIN_PRI = pkg_rolhas::MIN_PRI
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic [6:0] pri_count,
  input  logic [6:0] sec_count,
  output estado_t    estado,
  output logic       sec_dec,
  output logic       falta_sec
);

  localparam logic [6:0] CAP_V = 7'(CAP_PRI);
  localparam logic [6:0] MIN_V = 7'(MIN_PRI);

  estado_t nxt;
  logic    baixo;
  logic    cheio;
  logic    sec_vazio;

  assign baixo     = pri_count < MIN_V;
  assign cheio     = pri_count == CAP_V;
  assign sec_vazio = sec_count == 7'd0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) estado <= IDLE;
    else     estado <= nxt;
  end

  always_comb begin
    nxt = estado;
    unique case (estado)
      IDLE: begin
        if (enable && baixo)
          nxt = sec_vazio ? STARVED : TRANSFER;
      end
      TRANSFER: nxt = SETTLE;
      SETTLE: begin
        if (!enable || cheio) nxt = IDLE;
        else if (sec_vazio)   nxt = STARVED;
        else                  nxt = TRANSFER;
      end
      STARVED: begin
        // A full reservoir never restarts a transfer
        if (enable && !sec_vazio && !cheio) nxt = TRANSFER;
        else if (!enable || !baixo)         nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign sec_dec   = estado == TRANSFER;
  assign falta_sec = estado == STARVED;

endmodule

// File: rtl/modulo_abastecimento_rolhas_principal.sv
// Primary cork reservoir: saturating count, refill FSM and status flags
// for the display encoders and the sealing FSM.
module modulo_abastecimento_rolhas_principal
  import pkg_rolhas::*;
#(
  parameter int CAP_PRI = pkg_rolhas::CAP_PRI,
  parameter int MIN_PRI = pkg_rolhas::MIN_PRI
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic       consome,
  input  logic [6:0] sec_count,
  output logic       sec_dec,
  output logic [6:0] pri_count,
  output logic       ro,
  output logic       pri_baixo,
  output logic       transferindo,
  output logic       falta_sec
);

  localparam logic [6:0] CAP_V = 7'(CAP_PRI);
  localparam logic [6:0] MIN_V = 7'(MIN_PRI);

  estado_t    estado;
  logic [6:0] pri_q;
  logic [6:0] pri_d;
  logic       sobe;
  logic       desce;

  modulo_mef_transferencia_rolhas #(
    .CAP_PRI (CAP_PRI),
    .MIN_PRI (MIN_PRI)
  ) u_mef (
    .clk       (clk),
    .clr       (clr),
    .enable    (enable),
    .pri_count (pri_q),
    .sec_count (sec_count),
    .estado    (estado),
    .sec_dec   (sec_dec),
    .falta_sec (falta_sec)
  );

  // Consume at zero is ignored, so a transfer then nets +1
  assign sobe  = (estado == TRANSFER) && (pri_q != CAP_V);
  assign desce = consome && (pri_q != 7'd0);

  always_comb begin
    pri_d = pri_q + 7'(sobe) - 7'(desce);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) pri_q <= '0;
    else     pri_q <= pri_d;
  end

  assign pri_count    = pri_q;
  assign ro           = pri_q == 7'd0;
  assign pri_baixo    = pri_q < MIN_V;
  assign transferindo = (estado == TRANSFER) || (estado == SETTLE);

endmodule

// File: tb/tb_modulo_abastecimento_rolhas_principal.sv
// Bench for the primary cork reservoir: scenario tasks checked against
// a cycle-level behavioural model of the refill rules.
module tb_modulo_abastecimento_rolhas_principal;

  localparam int CAP = 15;
  localparam int MIN = 5;

  typedef enum {M_IDLE, M_TR, M_SE, M_ST} mst_t;

  logic       clk = 1'b0;
  logic       clr;
  logic       enable;
  logic       consome;
  logic [6:0] sec_count;
  logic       sec_dec;
  logic [6:0] pri_count;
  logic       ro;
  logic       pri_baixo;
  logic       transferindo;
  logic       falta_sec;

  int   total = 0;
  int   bad = 0;
  int   dut_dec = 0;
  mst_t m_st = M_IDLE;
  int   m_pri = 0;

  logic [11:0] obs;
  assign obs = {pri_count, sec_dec, ro, pri_baixo, transferindo, falta_sec};

  localparam logic [11:0] RST_V = {7'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  modulo_abastecimento_rolhas_principal dut (
    .clk          (clk),
    .clr          (clr),
    .enable       (enable),
    .consome      (consome),
    .sec_count    (sec_count),
    .sec_dec      (sec_dec),
    .pri_count    (pri_count),
    .ro           (ro),
    .pri_baixo    (pri_baixo),
    .transferindo (transferindo),
    .falta_sec    (falta_sec)
  );

  always #5 clk = ~clk;

  function logic [11:0] expv();
    return {7'(m_pri), m_st == M_TR, m_pri == 0, m_pri < MIN,
            (m_st == M_TR) || (m_st == M_SE), m_st == M_ST};
  endfunction

  task automatic step(input logic en, input logic cons);
    mst_t ns;
    int   np;
    logic was_tr;
    enable  = en;
    consome = cons;
    dut_dec += int'(sec_dec);
    was_tr = (m_st == M_TR);
    ns = m_st;
    case (m_st)
      M_IDLE:
        if (en && m_pri < MIN) ns = (sec_count != 0) ? M_TR : M_ST;
      M_TR: ns = M_SE;
      M_SE:
        if (!en || m_pri == CAP) ns = M_IDLE;
        else if (sec_count == 0) ns = M_ST;
        else ns = M_TR;
      M_ST:
        if (en && sec_count != 0) ns = M_TR;
        else if (!en || m_pri >= MIN) ns = M_IDLE;
      default: ns = M_IDLE;
    endcase
    np = m_pri;
    if (was_tr && m_pri < CAP) np = np + 1;
    if (cons && m_pri > 0) np = np - 1;
    @(posedge clk);
    #1;
    m_st  = ns;
    m_pri = np;
    if (was_tr && sec_count != 0) sec_count = sec_count - 7'd1;
    consome = 1'b0;
  endtask

  task automatic reset_dut();
    clr = 1'b1;
    enable = 1'b0;
    consome = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0;
    m_st = M_IDLE;
    m_pri = 0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    enable = 1'b0;
    consome = 1'b0;
    sec_count = 7'd20;
    #3;
    total++;
    if (obs !== RST_V) begin
      bad++;
      $display("FAIL reset_async got=%h want=%h", obs, RST_V);
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
    m_st = M_IDLE;
    m_pri = 0;
    total++;
    if (pri_count !== 7'd0 || ro !== 1'b1) begin
      bad++;
      $display("FAIL reset_count got=%0d ro=%b want=0 ro=1", pri_count, ro);
    end
  endtask

  task automatic test_refill_full();
    int d0;
    int first_low;
    d0 = dut_dec;
    first_low = -1;
    for (int i = 1; i <= 34; i++) begin
      step(1'b1, 1'b0);
      if (first_low < 0 && ro === 1'b0) first_low = i;
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL refill step=%0d got=%h want=%h", i, obs, expv());
      end
    end
    total++;
    if (dut_dec - d0 !== 15) begin
      bad++;
      $display("FAIL refill_pulses got=%0d want=15", dut_dec - d0);
    end
    total++;
    if (pri_count !== 7'd15 || transferindo !== 1'b0) begin
      bad++;
      $display("FAIL refill_end got=%0d tr=%b want=15 tr=0",
               pri_count, transferindo);
    end
    total++;
    if (first_low !== 2 || sec_count !== 7'd5) begin
      bad++;
      $display("FAIL refill_ro got=%0d sec=%0d want=2 sec=5",
               first_low, sec_count);
    end
  endtask

  task automatic test_drain_starve();
    int   d0;
    logic seen;
    int   p;
    sec_count = 7'd3;
    d0 = dut_dec;
    seen = 1'b0;
    p = -1;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL drain step=%0d got=%h want=%h", i, obs, expv());
      end
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      if (!seen && falta_sec === 1'b1) begin
        seen = 1'b1;
        p = int'(pri_count);
      end
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL starve step=%0d got=%h want=%h", i, obs, expv());
      end
    end
    total++;
    if (!seen || p !== 7) begin
      bad++;
      $display("FAIL starve_flag got=%b/%0d want=1/7", seen, p);
    end
    total++;
    if (dut_dec - d0 !== 3 || sec_count !== 7'd0) begin
      bad++;
      $display("FAIL starve_pulses got=%0d sec=%0d want=3 sec=0",
               dut_dec - d0, sec_count);
    end
  endtask

  task automatic test_starve_resume();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL hold_starved step=%0d got=%h want=%h", i, obs, expv());
      end
    end
    total++;
    if (falta_sec !== 1'b1 || pri_count !== 7'd4) begin
      bad++;
      $display("FAIL starved got=%b/%0d want=1/4", falta_sec, pri_count);
    end
    sec_count = 7'd20;
    step(1'b1, 1'b0);
    total++;
    if (sec_dec !== 1'b1 || transferindo !== 1'b1 || falta_sec !== 1'b0) begin
      bad++;
      $display("FAIL resume got=%b%b%b want=110",
               sec_dec, transferindo, falta_sec);
    end
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0);
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL resume step=%0d got=%h want=%h", i, obs, expv());
      end
    end
    total++;
    if (pri_count !== 7'd15 || sec_count !== 7'd9) begin
      bad++;
      $display("FAIL resume_end got=%0d sec=%0d want=15 sec=9",
               pri_count, sec_count);
    end
  endtask

  task automatic test_consume_on_transfer();
    int cnt;
    logic c;
    cnt = 0;
    sec_count = 7'd50;
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (sec_dec === 1'b1) cnt++;
      c = (m_st == M_TR);
      step(1'b1, c);
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL cons_tr step=%0d got=%h want=%h", i, obs, expv());
      end
    end
    total++;
    if (cnt !== 10 || pri_count !== 7'd4 || sec_count !== 7'd40) begin
      bad++;
      $display("FAIL cons_tr_sum got=%0d/%0d/%0d want=10/4/40",
               cnt, pri_count, sec_count);
    end
  endtask

  task automatic test_empty_disabled();
    int d0;
    reset_dut();
    sec_count = 7'd30;
    d0 = dut_dec;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, (i % 2) == 0);
      total++;
      if (pri_count !== 7'd0 || ro !== 1'b1 || sec_dec !== 1'b0) begin
        bad++;
        $display("FAIL empty step=%0d got=%0d ro=%b dec=%b want=0 1 0",
                 i, pri_count, ro, sec_dec);
      end
    end
    total++;
    if (dut_dec - d0 !== 0) begin
      bad++;
      $display("FAIL empty_pulses got=%0d want=0", dut_dec - d0);
    end
  endtask

  task automatic test_clr_mid_transfer();
    reset_dut();
    sec_count = 7'd20;
    step(1'b1, 1'b0);
    total++;
    if (sec_dec !== 1'b1) begin
      bad++;
      $display("FAIL clr_pre got=%b want=1", sec_dec);
    end
    #2;
    clr = 1'b1;
    #1;
    m_st = M_IDLE;
    m_pri = 0;
    total++;
    if (obs !== RST_V) begin
      bad++;
      $display("FAIL clr_async got=%h want=%h", obs, RST_V);
    end
    @(posedge clk);
    #1;
    total++;
    if (obs !== RST_V || sec_count !== 7'd20) begin
      bad++;
      $display("FAIL clr_hold got=%h sec=%0d want=%h sec=20",
               obs, sec_count, RST_V);
    end
    clr = 1'b0;
    step(1'b0, 1'b0);
    total++;
    if (sec_dec !== 1'b0 || obs !== expv()) begin
      bad++;
      $display("FAIL clr_after got=%h want=%h", obs, expv());
    end
  endtask

  task automatic test_random();
    logic en;
    logic c;
    reset_dut();
    sec_count = 7'($urandom_range(0, 99));
    for (int i = 0; i < 400; i++) begin
      if (m_st != M_TR && $urandom_range(0, 15) == 0)
        sec_count = 7'($urandom_range(0, 99));
      en = $urandom_range(0, 9) != 0;
      c = $urandom_range(0, 2) == 0;
      step(en, c);
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL random step=%0d got=%h want=%h", i, obs, expv());
      end
    end
  endtask

  initial begin
    clr = 1'b1;
    enable = 1'b0;
    consome = 1'b0;
    sec_count = 7'd0;
    test_reset();
    test_refill_full();
    test_drain_starve();
    test_starve_resume();
    test_consume_on_transfer();
    test_empty_disabled();
    test_clr_mid_transfer();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
